cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing controller for the 2-way set-associative Cache array (two ways, ram0/ram1, hit flags HIT0/HIT1, outputs dout0/dout1).
- Accepts single-word CPU read/write requests, performs lookup, and refills missed lines from main memory into the LRU way.
- Write policy is write-through, no-write-allocate.
- Sits between the CPU load/store port, the Cache array and the memory bus.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
INDEX_W, 4, set index width (16 sets); index = addr[8:5]
WOFF_W, 3, word-offset width (8 words/line); word = addr[4:2]; addr[1:0] byte offset, ignored
TAG_W, ADDR_W-INDEX_W-WOFF_W-2, tag = addr[31:9]

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
cpu_req  in  1  request valid; held until cpu_ready
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  request address
cpu_wdata  in  DATA_W  write data
cpu_rdata  out  DATA_W  read data, valid when cpu_ready
cpu_ready  out  1  one-cycle completion pulse
cache_addr  out  ADDR_W  to Cache addr_in
cache_we  out  1  to Cache we
cache_sel0  out  1  to Cache sel0 (write way 0)
cache_sel1  out  1  to Cache sel1 (write way 1)
cache_di0  out  DATA_W  to Cache di0
cache_di1  out  DATA_W  to Cache di1
cache_hit0  in  1  from Cache HIT0
cache_hit1  in  1  from Cache HIT1
cache_dout0  in  DATA_W  from Cache dout0
cache_dout1  in  DATA_W  from Cache dout1
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  word-aligned memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion; ignored while mem_req=0

Behaviour:
- Cache array contract: HIT0/HIT1/dout0/dout1 are combinational from addr_in; a write with we=1 and selN=1 stores data and tag(addr_in) into way N at the rising edge.
- Reset: state=IDLE; LRU table all 0; cpu_ready=0, cpu_rdata=0; all cache_* and mem_* outputs 0. Reset mid-refill or mid-write-through aborts at once, drops mem_req the next cycle and leaves the partial line in place. The line is not trusted; it is simply overwritten on the next miss.
- States: IDLE, LOOKUP, REFILL, WTHRU.
- IDLE: when cpu_req=1 and cpu_ready=0, latch addr/we/wdata and go to LOOKUP. cpu_* inputs are not resampled until the next IDLE.
- LOOKUP: cache_addr=latched addr.
  - Read hit (hit0|hit1): cpu_ready=1; cpu_rdata = hit0 ? dout0 : dout1; lru[index] = non-hit way; go to IDLE. Read-hit latency is 2 cycles from cpu_req to cpu_ready.
  - Read miss: victim = lru[index]; clear word counter; go to REFILL.
  - Write hit: cache_we=1, sel of hit way, diN=wdata; lru update as for a read hit; go to WTHRU.
  - Write miss: go to WTHRU with no cache write and no LRU change.
  - Both hits set (illegal): way 0 wins.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={tag,index,cnt,2'b00}.
  - On mem_ack: cache_we=1, victim sel=1, cache_addr=same as mem_addr, victim di=mem_rdata, cnt++.
  - After the ack of word 7 (cnt wraps 7->0), go to LOOKUP; the re-lookup hits and completes.
  - mem_req deasserts for one cycle between words.
- WTHRU: mem_req=1, mem_we=1, mem_addr=latched addr & ~3, mem_wdata=wdata. On mem_ack: cpu_ready=1, go to IDLE.
- cpu_ready and cache_we are single-cycle pulses and never asserted in IDLE.

Decomposition:
- Shared include cache_defs.vh holds the state encodings (IDLE=0, LOOKUP=1, REFILL=2, WTHRU=3) and the tag/index/word field slice constants, shared with Cache.
- One sub-module, cache_lru: 2^INDEX_W x 1-bit table with sync reset, a read port, and a write port (index, value, en).

Test Plan:
- Reset, then read 0x100 (cold miss, mem returns 0xA0+word) -> 8 reads at 0x100..0x11C, way 0 filled, cpu_rdata=0xA0, lru[8]=1.
- Re-read 0x104 -> no mem_req, cpu_ready 2 cycles after cpu_req, cpu_rdata=0xA1.
- Read 0x300 (same index 8, new tag) -> refill into way 1, rdata from memory; then read 0x500 -> evicts way 0 (lru[8]=0), and 0x300 still hits.
- Write 0x120=0x15 (hit in set 9 after prior fill) -> cache write to hit way, mem write 0x120/0x15, re-read returns 0x15; write to an unmapped address -> mem write only, cache contents unchanged.
- Assert rst during REFILL word 3 -> all outputs 0 next cycle, state IDLE; a following read of the same address refills all 8 words again.
- Delay mem_ack by 5 cycles -> mem_req/mem_addr stay stable until ack, and cpu_ready is not asserted early.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types, field geometry and address helpers for the cache controller.
package cache_ctrl_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned INDEX_W   = 4;
    localparam int unsigned WOFF_W    = 3;
    localparam int unsigned BOFF_W    = 2;
    localparam int unsigned TAG_W     = ADDR_W - INDEX_W - WOFF_W - BOFF_W;
    localparam int unsigned NUM_SETS  = 1 << INDEX_W;
    localparam int unsigned WOFF_LSB  = BOFF_W;
    localparam int unsigned INDEX_LSB = WOFF_LSB + WOFF_W;
    localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

    localparam logic [WOFF_W-1:0] LAST_WORD = '1;

    // Encodings are shared with the Cache array.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        WTHRU  = 2'd3
    } state_t;

    // CPU request latched in IDLE and held for the whole transaction.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[TAG_LSB +: TAG_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_word_addr(input logic [TAG_W-1:0]   tag,
                                                         input logic [INDEX_W-1:0] index,
                                                         input logic [WOFF_W-1:0]  word);
        return {tag, index, word, BOFF_W'(0)};
    endfunction

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:BOFF_W], BOFF_W'(0)};
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU bit: the value names the way to evict on the next miss.
module cache_lru
    import cache_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_way_c,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_way,
    input  logic               wr_en
);

    logic [NUM_SETS-1:0] lru_q;

    assign rd_way_c = lru_q[rd_index];

    // Table update; reset makes way 0 the first victim of every set.
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_q <= '0;
        end else if (wr_en) begin
            lru_q[wr_index] <= wr_way;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer for a 2-way set-associative cache: lookup, LRU refill on read
// miss, write-through without allocate on writes.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_we,
    output logic              cache_sel0,
    output logic              cache_sel1,
    output logic [DATA_W-1:0] cache_di0,
    output logic [DATA_W-1:0] cache_di1,
    input  logic              cache_hit0,
    input  logic              cache_hit1,
    input  logic [DATA_W-1:0] cache_dout0,
    input  logic [DATA_W-1:0] cache_dout1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t             state;
    req_t               req_q;
    logic [WOFF_W-1:0]  cnt;
    logic               victim;
    logic [INDEX_W-1:0] index_c;
    logic               lru_way_c;
    logic               hit_any_c;
    logic               lru_wr_en_c;

    assign index_c     = addr_index(req_q.addr);
    assign hit_any_c   = cache_hit0 | cache_hit1;
    // A pending cache_we in LOOKUP is the last refill word, not a real lookup.
    assign lru_wr_en_c = (state == LOOKUP) && !cache_we && hit_any_c;

    // On a hit the other way becomes LRU; way 0 wins when both flags are set.
    cache_lru u_lru (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index_c),
        .rd_way_c (lru_way_c),
        .wr_index (index_c),
        .wr_way   (cache_hit0),
        .wr_en    (lru_wr_en_c)
    );

    // Controller FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_q      <= '0;
            cnt        <= '0;
            victim     <= 1'b0;
            cpu_rdata  <= '0;
            cpu_ready  <= 1'b0;
            cache_addr <= '0;
            cache_we   <= 1'b0;
            cache_sel0 <= 1'b0;
            cache_sel1 <= 1'b0;
            cache_di0  <= '0;
            cache_di1  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_ready  <= 1'b0;
            cache_we   <= 1'b0;
            cache_sel0 <= 1'b0;
            cache_sel1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (cpu_req && !cpu_ready) begin
                        req_q      <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
                        cache_addr <= cpu_addr;
                        state      <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (cache_we) begin
                        // Last refill word commits this cycle; re-point at the request.
                        cache_addr <= req_q.addr;
                    end else if (hit_any_c && !req_q.we) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= cache_hit0 ? cache_dout0 : cache_dout1;
                        state     <= IDLE;
                    end else if (req_q.we) begin
                        if (hit_any_c) begin
                            cache_we   <= 1'b1;
                            cache_sel0 <= cache_hit0;
                            cache_sel1 <= !cache_hit0;
                            if (cache_hit0) begin
                                cache_di0 <= req_q.wdata;
                            end else begin
                                cache_di1 <= req_q.wdata;
                            end
                        end
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= word_align(req_q.addr);
                        mem_wdata <= req_q.wdata;
                        state     <= WTHRU;
                    end else begin
                        victim   <= lru_way_c;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= line_word_addr(addr_tag(req_q.addr), index_c, WOFF_W'(0));
                        state    <= REFILL;
                    end
                end

                REFILL: begin
                    if (mem_req) begin
                        if (mem_ack) begin
                            mem_req    <= 1'b0;
                            cache_we   <= 1'b1;
                            cache_sel0 <= !victim;
                            cache_sel1 <= victim;
                            cache_addr <= mem_addr;
                            if (victim) begin
                                cache_di1 <= mem_rdata;
                            end else begin
                                cache_di0 <= mem_rdata;
                            end
                            cnt <= cnt + WOFF_W'(1);
                            if (cnt == LAST_WORD) begin
                                state <= LOOKUP;
                            end
                        end
                    end else begin
                        // One idle cycle between words, then request the next one.
                        mem_req  <= 1'b1;
                        mem_addr <= line_word_addr(addr_tag(req_q.addr), index_c, cnt);
                    end
                end

                WTHRU: begin
                    if (mem_req && mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural Cache array and memory around the DUT,
// a transaction-level reference model, and a per-cycle compare process.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [31:0] cache_addr;
    logic        cache_we;
    logic        cache_sel0;
    logic        cache_sel1;
    logic [31:0] cache_di0;
    logic [31:0] cache_di1;
    logic        cache_hit0;
    logic        cache_hit1;
    logic [31:0] cache_dout0;
    logic [31:0] cache_dout1;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    cache_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .cache_addr  (cache_addr),
        .cache_we    (cache_we),
        .cache_sel0  (cache_sel0),
        .cache_sel1  (cache_sel1),
        .cache_di0   (cache_di0),
        .cache_di1   (cache_di1),
        .cache_hit0  (cache_hit0),
        .cache_hit1  (cache_hit1),
        .cache_dout0 (cache_dout0),
        .cache_dout1 (cache_dout1),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- Cache array (environment) ----------------
    logic        ca_valid [2][16];
    logic [22:0] ca_tag   [2][16];
    logic [31:0] ca_data  [2][16][8];

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++)
                for (int s = 0; s < 16; s++)
                    ca_valid[w][s] <= 1'b0;
        end else if (cache_we) begin
            if (cache_sel0) begin
                ca_valid[0][cache_addr[8:5]] <= 1'b1;
                ca_tag[0][cache_addr[8:5]]   <= cache_addr[31:9];
                ca_data[0][cache_addr[8:5]][cache_addr[4:2]] <= cache_di0;
            end
            if (cache_sel1) begin
                ca_valid[1][cache_addr[8:5]] <= 1'b1;
                ca_tag[1][cache_addr[8:5]]   <= cache_addr[31:9];
                ca_data[1][cache_addr[8:5]][cache_addr[4:2]] <= cache_di1;
            end
        end
    end

    always_comb begin
        cache_hit0  = ca_valid[0][cache_addr[8:5]] && (ca_tag[0][cache_addr[8:5]] == cache_addr[31:9]);
        cache_hit1  = ca_valid[1][cache_addr[8:5]] && (ca_tag[1][cache_addr[8:5]] == cache_addr[31:9]);
        cache_dout0 = ca_data[0][cache_addr[8:5]][cache_addr[4:2]];
        cache_dout1 = ca_data[1][cache_addr[8:5]][cache_addr[4:2]];
    end

    // ---------------- Main memory (environment) ----------------
    logic [31:0] mem [logic [31:0]];
    int          ack_delay = 0;
    int          ack_cnt   = 0;

    // Unwritten words: 0xA0 + word, plus 0x100 per line above line 8.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem.exists(wa)) return mem[wa];
        return 32'hA0 + 32'(a[4:2]) + ((32'(a[31:5]) - 32'd8) << 8);
    endfunction

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ack) begin
            mem_ack <= 1'b0;
            ack_cnt <= 0;
        end else if (ack_cnt >= ack_delay) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem_rd(mem_addr);
        end else begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    // ---------------- Reference model ----------------
    typedef struct packed { logic [31:0] addr; logic we; logic [31:0] data; } mop_t;
    typedef struct packed { logic [31:0] addr; logic way; logic [31:0] data; } cw_t;

    mop_t        exp_mem[$];
    cw_t         exp_cw[$];
    bit          m_valid [2][16];
    logic [22:0] m_tag   [2][16];
    bit          m_lru   [16];
    bit          pending   = 1'b0;
    bit          exp_read  = 1'b0;
    logic [31:0] exp_rdata = '0;
    int          mem_seen  = 0;
    int          cw_seen   = 0;

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 16; s++)
                m_valid[w][s] = 1'b0;
        for (int s = 0; s < 16; s++) m_lru[s] = 1'b0;
        exp_mem.delete();
        exp_cw.delete();
        pending = 1'b0;
    endtask

    // Queue up everything one CPU request must cause.
    task automatic model_req(input logic we, input logic [31:0] a, input logic [31:0] wd, output bit hit);
        int          idx;
        int          hw;
        logic [22:0] tg;
        logic [31:0] wa;
        idx = int'(a[8:5]);
        tg  = a[31:9];
        hit = 1'b0;
        hw  = 0;
        if (m_valid[0][idx] && m_tag[0][idx] == tg) begin
            hit = 1'b1; hw = 0;
        end else if (m_valid[1][idx] && m_tag[1][idx] == tg) begin
            hit = 1'b1; hw = 1;
        end
        if (!we) begin
            if (!hit) begin
                hw = m_lru[idx] ? 1 : 0;
                for (int w = 0; w < 8; w++) begin
                    wa = {a[31:5], 3'(w), 2'b00};
                    exp_mem.push_back('{addr: wa, we: 1'b0, data: 32'd0});
                    exp_cw.push_back('{addr: wa, way: (hw == 1), data: mem_rd(wa)});
                end
                m_valid[hw][idx] = 1'b1;
                m_tag[hw][idx]   = tg;
            end
            m_lru[idx] = (hw == 0);
            exp_rdata  = mem_rd(a);
            exp_read   = 1'b1;
        end else begin
            if (hit) begin
                exp_cw.push_back('{addr: a, way: (hw == 1), data: wd});
                m_lru[idx] = (hw == 0);
            end
            exp_mem.push_back('{addr: {a[31:2], 2'b00}, we: 1'b1, data: wd});
            exp_read = 1'b0;
        end
    endtask

    // ---------------- Per-cycle compare ----------------
    initial begin : compare
        logic        prev_req;
        logic        prev_ack;
        logic        prev_we;
        logic [31:0] prev_addr;
        mop_t        me;
        cw_t         ce;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_we   = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_req && !prev_ack) begin
                    chk("mem_req_held", 32'(mem_req), 32'd1);
                    if (mem_req) begin
                        chk("mem_addr_stable", mem_addr, prev_addr);
                        chk("mem_we_stable", 32'(mem_we), 32'(prev_we));
                    end
                end
                if (prev_req && prev_ack) chk("mem_req_gap", 32'(mem_req), 32'd0);
                if (mem_req && mem_ack) begin
                    mem_seen++;
                    if (exp_mem.size() == 0) begin
                        fail("unexpected_mem_op", mem_addr, 32'd0);
                    end else begin
                        me = exp_mem.pop_front();
                        chk("mem_addr", mem_addr, me.addr);
                        chk("mem_we", 32'(mem_we), 32'(me.we));
                        if (me.we) chk("mem_wdata", mem_wdata, me.data);
                    end
                    if (mem_we) mem[{mem_addr[31:2], 2'b00}] = mem_wdata;
                end
                if (cache_we) begin
                    cw_seen++;
                    if (exp_cw.size() == 0) begin
                        fail("unexpected_cache_write", cache_addr, 32'd0);
                    end else begin
                        ce = exp_cw.pop_front();
                        chk("cw_addr", cache_addr, ce.addr);
                        chk("cw_sel0", 32'(cache_sel0), 32'(!ce.way));
                        chk("cw_sel1", 32'(cache_sel1), 32'(ce.way));
                        chk("cw_data", ce.way ? cache_di1 : cache_di0, ce.data);
                    end
                end
                if (cpu_ready) begin
                    if (!pending) begin
                        fail("spurious_cpu_ready", 32'd1, 32'd0);
                    end else begin
                        chk("mem_ops_left", 32'(exp_mem.size()), 32'd0);
                        chk("cache_writes_left", 32'(exp_cw.size()), 32'd0);
                        if (exp_read) chk("cpu_rdata", cpu_rdata, exp_rdata);
                        pending = 1'b0;
                    end
                end
            end
            prev_req  = rst ? 1'b0 : mem_req;
            prev_ack  = mem_ack;
            prev_we   = mem_we;
            prev_addr = mem_addr;
        end
    end

    // ---------------- Stimulus ----------------
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output bit hit);
        model_req(we, a, wd, hit);
        pending   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_req   = 1'b1;
        lat       = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_ready) break;
        end
        if (!cpu_ready) begin
            fail("request_timeout", 32'd0, 32'd1);
            exp_mem.delete();
            exp_cw.delete();
            pending = 1'b0;
        end
        cpu_req = 1'b0;
        if (hit && !we) chk("hit_latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cpu_ready"}, 32'(cpu_ready), 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_cache_addr"}, cache_addr, 32'd0);
        chk({tag, "_cache_ctl"}, {29'd0, cache_we, cache_sel0, cache_sel1}, 32'd0);
        chk({tag, "_cache_di0"}, cache_di0, 32'd0);
        chk({tag, "_cache_di1"}, cache_di1, 32'd0);
        chk({tag, "_mem_ctl"}, {30'd0, mem_req, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        bit hit;
        int base_mem;
        int base_cw;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss: way 0 of set 8 filled from memory.
        base_mem = mem_seen;
        do_req(1'b0, 32'h100, 32'd0, lat, hit);
        chk("cold_rdata", cpu_rdata, 32'hA0);
        chk("cold_mem_reads", 32'(mem_seen - base_mem), 32'd8);
        chk("cold_way0_valid", 32'(ca_valid[0][8]), 32'd1);
        chk("cold_way0_tag", 32'(ca_tag[0][8]), 32'd0);

        // Re-read a word of the same line: pure hit.
        base_mem = mem_seen;
        do_req(1'b0, 32'h104, 32'd0, lat, hit);
        chk("hit_rdata", cpu_rdata, 32'hA1);
        chk("hit_lat_literal", 32'(lat), 32'd2);
        chk("hit_no_mem", 32'(mem_seen - base_mem), 32'd0);

        // Same set, new tag: goes to way 1; then the next conflict evicts way 0.
        do_req(1'b0, 32'h300, 32'd0, lat, hit);
        chk("way1_rdata", cpu_rdata, 32'h10A0);
        chk("way1_tag", 32'(ca_tag[1][8]), 32'd1);
        do_req(1'b0, 32'h500, 32'd0, lat, hit);
        chk("evict_rdata", cpu_rdata, 32'h20A0);
        chk("evict_way0_tag", 32'(ca_tag[0][8]), 32'd2);
        do_req(1'b0, 32'h300, 32'd0, lat, hit);
        chk("survivor_rdata", cpu_rdata, 32'h10A0);

        // Write hit in set 9, then read back.
        do_req(1'b0, 32'h120, 32'd0, lat, hit);
        chk("set9_rdata", cpu_rdata, 32'h1A0);
        do_req(1'b1, 32'h120, 32'h15, lat, hit);
        chk("wthru_mem_value", mem_rd(32'h120), 32'h15);
        do_req(1'b0, 32'h120, 32'd0, lat, hit);
        chk("write_readback", cpu_rdata, 32'h15);

        // Write miss: memory only, no allocation.
        base_cw = cw_seen;
        do_req(1'b1, 32'h1000, 32'hDEAD, lat, hit);
        chk("wmiss_no_cache_write", 32'(cw_seen - base_cw), 32'd0);
        chk("wmiss_set0_invalid", 32'(ca_valid[0][0] | ca_valid[1][0]), 32'd0);
        do_req(1'b0, 32'h1000, 32'd0, lat, hit);
        chk("wmiss_readback", cpu_rdata, 32'hDEAD);

        // Slow memory: requests must hold steady until acknowledged.
        ack_delay = 5;
        do_req(1'b0, 32'h340, 32'd0, lat, hit);
        chk("slow_rdata", cpu_rdata, 32'h12A0);
        do_req(1'b1, 32'h344, 32'h77, lat, hit);
        ack_delay = 0;
        do_req(1'b0, 32'h344, 32'd0, lat, hit);
        chk("slow_write_readback", cpu_rdata, 32'h77);

        // Reset while word 3 of a refill is outstanding.
        ack_delay = 4;
        model_req(1'b0, 32'h2C0, 32'd0, hit);
        pending   = 1'b1;
        base_cw   = cw_seen;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h2C0;
        cpu_req   = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            if ((cw_seen - base_cw) >= 3 && mem_req) break;
        end
        chk("abort_point_words", 32'(cw_seen - base_cw), 32'd3);
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        rst = 1'b0;
        model_reset();
        ack_delay = 0;
        @(posedge clk);
        #1;
        base_mem = mem_seen;
        do_req(1'b0, 32'h2C0, 32'd0, lat, hit);
        chk("refill_again_reads", 32'(mem_seen - base_mem), 32'd8);
        chk("refill_again_rdata", cpu_rdata, 32'hEA0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
